// File: rtl/keypad_entry_scanner.sv
// 4x4 active-low keypad scanner with tick-based press/release debounce; each accepted
// digit becomes a one-cycle write (num/sel/wr) into the display register bank.
module keypad_entry_scanner #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_TICKS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] num,
    output logic [1:0] sel,
    output logic       wr
);

    localparam int unsigned TW = $clog2(SCAN_DIV);
    localparam int unsigned DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_DONE   = DW'(DEBOUNCE_TICKS);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_ACCEPT   = 2'd2,
        ST_HELD     = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    col_meta_q, col_sync_q;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [1:0]    row_q, row_d;
    logic [3:0]    col_lat_q, col_lat_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [DW-1:0] rcnt_q, rcnt_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_held_q, key_held_d;
    logic [3:0]    num_q, num_d;
    logic [1:0]    sel_q, sel_d;

    logic          tick;
    logic          one_key;
    logic [1:0]    col_idx;
    logic [3:0]    map_code;
    logic          load;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // A key is recognised only when exactly one column reads low.
    always_comb begin
        one_key = 1'b0;
        col_idx = 2'd0;
        case (col_sync_q)
            4'b1110: begin one_key = 1'b1; col_idx = 2'd0; end
            4'b1101: begin one_key = 1'b1; col_idx = 2'd1; end
            4'b1011: begin one_key = 1'b1; col_idx = 2'd2; end
            4'b0111: begin one_key = 1'b1; col_idx = 2'd3; end
            default: begin one_key = 1'b0; col_idx = 2'd0; end
        endcase
    end

    assign tick     = (tcnt_q == TICK_LAST);
    assign tcnt_d   = tick ? '0 : tcnt_q + TW'(1);
    assign map_code = key_map(row_q, col_idx);

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_lat_d  = col_lat_q;
        dcnt_d     = dcnt_q;
        rcnt_d     = rcnt_q;
        ptr_d      = ptr_q;
        key_held_d = key_held_q;
        load       = 1'b0;

        case (state_q)
            ST_SCAN: begin
                if (tick) begin
                    if (one_key) begin
                        col_lat_d = col_sync_q;
                        dcnt_d    = DW'(1);
                        if (DEBOUNCE_TICKS == 1) begin
                            load    = 1'b1;
                            state_d = ST_ACCEPT;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (tick) begin
                    if (col_sync_q == col_lat_q) begin
                        dcnt_d = dcnt_q + DW'(1);
                        if (dcnt_q + DW'(1) == DB_DONE) begin
                            load    = 1'b1;
                            state_d = ST_ACCEPT;
                        end
                    end else begin
                        row_d   = row_q + 2'd1;
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_ACCEPT: begin
                rcnt_d  = '0;
                state_d = ST_HELD;
                if (key_code_q <= 4'd9) begin
                    ptr_d = ptr_q + 2'd1;
                end else if (key_code_q == 4'hE) begin
                    ptr_d = 2'd0;
                end
            end
            ST_HELD: begin
                if (tick) begin
                    if (col_sync_q == 4'hF) begin
                        rcnt_d = rcnt_q + DW'(1);
                        if (rcnt_q + DW'(1) == DB_DONE) begin
                            key_held_d = 1'b0;
                            row_d      = row_q + 2'd1;
                            state_d    = ST_SCAN;
                        end
                    end else begin
                        rcnt_d = '0;
                    end
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    // Code, num and sel are captured on entry so they are valid during the ACCEPT strobe.
    always_comb begin
        key_code_d = key_code_q;
        num_d      = num_q;
        sel_d      = sel_q;
        if (load) begin
            key_code_d = map_code;
            key_held_d_unused_guard();
            if (map_code <= 4'd9) begin
                num_d = map_code;
                sel_d = ptr_q;
            end
        end
    end

    function automatic void key_held_d_unused_guard();
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            col_meta_q <= 4'hF;
            col_sync_q <= 4'hF;
            tcnt_q     <= '0;
            state_q    <= ST_SCAN;
            row_q      <= 2'd0;
            col_lat_q  <= 4'hF;
            dcnt_q     <= '0;
            rcnt_q     <= '0;
            ptr_q      <= 2'd0;
            key_code_q <= 4'd0;
            key_held_q <= 1'b0;
            num_q      <= 4'd0;
            sel_q      <= 2'd0;
        end else begin
            col_meta_q <= col_n;
            col_sync_q <= col_meta_q;
            tcnt_q     <= tcnt_d;
            state_q    <= state_d;
            row_q      <= row_d;
            col_lat_q  <= col_lat_d;
            dcnt_q     <= dcnt_d;
            rcnt_q     <= rcnt_d;
            ptr_q      <= ptr_d;
            key_code_q <= key_code_d;
            key_held_q <= load ? 1'b1 : key_held_d;
            num_q      <= num_d;
            sel_q      <= sel_d;
        end
    end

    // Strobes are masked while reset is asserted so no pulse escapes in the reset cycle.
    assign key_valid = (state_q == ST_ACCEPT) && !reset;
    assign wr        = key_valid && (key_code_q <= 4'd9);
    assign row_n     = ~(4'b0001 << row_q);
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;
    assign num       = num_q;
    assign sel       = sel_q;

endmodule

// File: tb/tb_keypad_entry_scanner.sv
// Keypad scanner bench: a keypad model answers row drive; expected accepts are queued
// at press time and compared when key_valid pulses.
module tb_keypad_entry_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [3:0] num;
    logic [1:0] sel;
    logic       wr;

    always #5 clk = ~clk;

    keypad_entry_scanner #(
        .SCAN_DIV      (4),
        .DEBOUNCE_TICKS(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .col_n    (col_n),
        .row_n    (row_n),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held),
        .num      (num),
        .sel      (sel),
        .wr       (wr)
    );

    // Pressed-key matrix: key_mask[r] bit c set means key (r,c) is down.
    logic [3:0] key_mask [4];

    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (row_n[r] == 1'b0) col_n = col_n & ~key_mask[r];
        end
    end

    typedef struct packed {
        logic [3:0] code;
        logic       wr;
        logic [3:0] num;
        logic [1:0] sel;
    } exp_t;

    exp_t       sb [$];
    int         n_pass = 0;
    int         n_chk  = 0;
    int         tb_ptr;
    logic [3:0] last_num;
    logic [1:0] last_sel;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [3:0] tb_map(input int r, input int c);
        logic [63:0] tbl;
        tbl = 64'h123A_456B_789C_E0FD;
        return tbl[63 - (r * 16 + c * 4) -: 4];
    endfunction

    task automatic push_exp(input int r, input int c);
        exp_t e;
        e.code = tb_map(r, c);
        if (e.code <= 4'd9) begin
            e.wr     = 1'b1;
            e.num    = e.code;
            e.sel    = 2'(tb_ptr);
            last_num = e.code;
            last_sel = 2'(tb_ptr);
            tb_ptr   = (tb_ptr + 1) % 4;
        end else begin
            e.wr  = 1'b0;
            e.num = last_num;
            e.sel = last_sel;
            if (e.code == 4'hE) tb_ptr = 0;
        end
        sb.push_back(e);
    endtask

    task automatic model_reset();
        tb_ptr   = 0;
        last_num = 4'd0;
        last_sel = 2'd0;
    endtask

    // Returns just after row r has been newly selected, so a press gets full ticks.
    task automatic wait_row(input int r);
        int n;
        logic [3:0] exp_row;
        exp_row = ~(4'b0001 << r);
        n = 0;
        while (row_n[r] === 1'b0 && n < 40) begin @(negedge clk); n++; end
        n = 0;
        while (row_n[r] !== 1'b0 && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) chk("row_wait_timeout", row_n, exp_row);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (key_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) chk("valid_timeout", key_valid, 1);
    endtask

    task automatic wait_release();
        int n;
        n = 0;
        while (key_held !== 1'b0 && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) chk("release_timeout", key_held, 0);
    endtask

    task automatic enter_key(input int r, input int c, input int hold);
        logic [3:0] m;
        m = 4'b0001 << c;
        wait_row(r);
        key_mask[r] = m;
        push_exp(r, c);
        wait_valid();
        repeat (hold) @(negedge clk);
        key_mask[r] = 4'd0;
        wait_release();
    endtask

    task automatic check_reset_vals();
        chk("rst_row_n",     row_n,     4'b1110);
        chk("rst_key_code",  key_code,  0);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_key_held",  key_held,  0);
        chk("rst_num",       num,       0);
        chk("rst_sel",       sel,       0);
        chk("rst_wr",        wr,        0);
    endtask

    // Scoreboard consumer: every key_valid must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_key_valid", key_valid, 0);
                end else begin
                    e = sb.pop_front();
                    chk("acc_key_code", key_code, e.code);
                    chk("acc_wr",       wr,       e.wr);
                    chk("acc_num",      num,      e.num);
                    chk("acc_sel",      sel,      e.sel);
                    chk("acc_key_held", key_held, 1);
                end
            end else if (wr !== 1'b0) begin
                chk("wr_without_valid", wr, 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int         changes;
        logic [3:0] prev_row;
        logic [3:0] exp_row;

        for (int r = 0; r < 4; r++) key_mask[r] = 4'd0;
        model_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        reset = 1'b0;

        // Idle scan: row advances every 4 clocks.
        for (int k = 0; k < 40; k++) begin
            if (k % 4 == 0) begin
                exp_row = ~(4'b0001 << ((k / 4) % 4));
                chk("idle_scan_row", row_n, exp_row);
            end
            @(negedge clk);
        end

        // Key '5' with exact release timing: key_held drops on the third quiet tick.
        wait_row(1);
        key_mask[1] = 4'b0010;
        push_exp(1, 1);
        wait_valid();
        key_mask[1] = 4'd0;
        chk("held_in_accept", key_held, 1);
        chk("row_held_accept", row_n, 4'b1101);
        repeat (11) @(negedge clk);
        chk("held_two_quiet_ticks", key_held, 1);
        @(negedge clk);
        chk("released_third_tick", key_held, 0);

        // Digit entry with pointer wrap, '*' resetting the pointer, long hold on '2'.
        enter_key(0, 0, 0);
        enter_key(0, 1, 40);
        enter_key(0, 2, 0);
        enter_key(1, 0, 0);
        enter_key(1, 2, 0);
        enter_key(3, 0, 0);
        enter_key(2, 0, 0);

        // Bounce on 'A': low 2 ticks, high 1 tick, then held stable.
        wait_row(0);
        key_mask[0] = 4'b1000;
        repeat (8) @(negedge clk);
        key_mask[0] = 4'd0;
        repeat (4) @(negedge clk);
        key_mask[0] = 4'b1000;
        push_exp(0, 3);
        wait_valid();
        key_mask[0] = 4'd0;
        wait_release();

        // Two columns low in one row is not a key; scanning continues.
        key_mask[1] = 4'b0011;
        changes  = 0;
        prev_row = row_n;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (row_n !== prev_row) changes++;
            prev_row = row_n;
        end
        chk("dual_col_row_changes", changes, 16);
        chk("dual_col_not_held", key_held, 0);
        key_mask[1] = 4'd0;

        // Reset in the middle of debounce.
        wait_row(1);
        key_mask[1] = 4'b0010;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals();
        key_mask[1] = 4'd0;
        reset = 1'b0;
        model_reset();
        repeat (30) @(negedge clk);

        // Reset while held after '8' advanced the pointer; '9' must land at sel 0.
        wait_row(2);
        key_mask[2] = 4'b0010;
        push_exp(2, 1);
        wait_valid();
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals();
        key_mask[2] = 4'd0;
        reset = 1'b0;
        model_reset();
        enter_key(2, 2, 0);

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
